rotary_quad_decoder: RTL

// - Consumes the debounced A/B quadrature pair from the rotary debouncer and converts it into detent steps.
// - Each step updates a bounded parameter value, e.g. a synth volume or pitch index, with saturating or wrapping limits.
// - Sits between the rotary debouncer and the synth control registers.
// - Outputs a registered value plus single-cycle step and error strobes.

---
 rtl/rotary_pkg.sv | 41 ++++
 rtl/quad_step_fsm.sv | 77 +++++++
 rtl/rotary_quad_decoder.sv | 94 +++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary quadrature decoder: Gray states, directions
// and the transition classifier used by the step FSM.
package rotary_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_INC  = 2'd1,
    T_DEC  = 2'd2,
    T_ERR  = 2'd3
  } trans_t;

  // Clockwise successor in the 00->01->11->10->00 sequence.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      S00:     n = S01;
      S01:     n = S11;
      S11:     n = S10;
      default: n = S00;
    endcase
    return n;
  endfunction

  function automatic trans_t decode_trans(input logic [1:0] prv, input logic [1:0] cur);
    trans_t t;
    if (cur == prv)               t = T_NONE;
    else if (cur == cw_next(prv)) t = T_INC;
    else if (prv == cw_next(cur)) t = T_DEC;
    else                          t = T_ERR;
    return t;
  endfunction

endpackage

// File: rtl/quad_step_fsm.sv
// Samples the A/B pair, classifies each Gray transition and accumulates
// sub-detent counts; emits combinational detent/dir/err strobes.
module quad_step_fsm
  import rotary_pkg::*;
#(
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic clr,
  output logic detent,
  output logic dir,
  output logic err
);

  localparam int ACC_W = 4;
  localparam logic signed [ACC_W-1:0] ACC_ONE = 4'sd1;
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(STEPS_PER_DETENT - 1);
  localparam logic signed [ACC_W-1:0] ACC_BOT = ACC_W'(1 - STEPS_PER_DETENT);

  logic [1:0] cur_q, cur_d;
  logic [1:0] prv_q, prv_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  trans_t trans;

  always_comb begin
    cur_d  = {a_in, b_in};
    prv_d  = cur_q;
    trans  = decode_trans(prv_q, cur_q);
    acc_d  = acc_q;
    detent = 1'b0;
    dir    = DIR_CW;
    err    = 1'b0;
    case (trans)
      T_INC: begin
        if (acc_q == ACC_TOP) begin
          detent = 1'b1;
          dir    = DIR_CW;
          acc_d  = '0;
        end else begin
          acc_d = acc_q + ACC_ONE;
        end
      end
      T_DEC: begin
        if (acc_q == ACC_BOT) begin
          detent = 1'b1;
          dir    = DIR_CCW;
          acc_d  = '0;
        end else begin
          acc_d = acc_q - ACC_ONE;
        end
      end
      T_ERR: begin
        err   = 1'b1;
        acc_d = '0;
      end
      default: ;
    endcase
    if (clr) acc_d = '0;
  end

  // prv is seeded with the live inputs so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= {a_in, b_in};
      prv_q <= {a_in, b_in};
      acc_q <= '0;
    end else begin
      cur_q <= cur_d;
      prv_q <= prv_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: turns detents from quad_step_fsm into a bounded
// parameter value with saturating or wrapping limits plus step/error strobes.
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int VAL_W            = 8,
  parameter int VAL_MIN          = 0,
  parameter int VAL_MAX          = 127,
  parameter int VAL_INIT         = 64,
  parameter int STEPS_PER_DETENT = 4,
  parameter int WRAP             = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [VAL_W-1:0] value,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             err_pulse,
  output logic             at_limit
);

  localparam logic [VAL_W-1:0] MIN_V  = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0] MAX_V  = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0] INIT_V = VAL_W'(VAL_INIT);
  localparam logic [VAL_W-1:0] ONE_V  = VAL_W'(1);
  localparam logic             INIT_LIM = (INIT_V == MIN_V) || (INIT_V == MAX_V);

  logic detent, dir, err;

  quad_step_fsm #(
    .STEPS_PER_DETENT(STEPS_PER_DETENT)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .clr    (clr),
    .detent (detent),
    .dir    (dir),
    .err    (err)
  );

  logic [VAL_W-1:0] value_q, value_d;
  logic step_pulse_q, step_pulse_d;
  logic step_dir_q, step_dir_d;
  logic err_pulse_q, err_pulse_d;
  logic at_limit_q, at_limit_d;

  // Limits are checked before the +/-1 so the arithmetic can never overflow.
  always_comb begin
    value_d      = value_q;
    step_pulse_d = detent;
    step_dir_d   = detent ? dir : step_dir_q;
    err_pulse_d  = err;
    if (clr) begin
      value_d = INIT_V;
    end else if (detent) begin
      if (dir == DIR_CW) begin
        if (value_q < MAX_V) value_d = value_q + ONE_V;
        else                 value_d = (WRAP != 0) ? MIN_V : MAX_V;
      end else begin
        if (value_q > MIN_V) value_d = value_q - ONE_V;
        else                 value_d = (WRAP != 0) ? MAX_V : MIN_V;
      end
    end
    at_limit_d = (value_d == MIN_V) || (value_d == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q      <= INIT_V;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      at_limit_q   <= INIT_LIM;
    end else begin
      value_q      <= value_d;
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
      err_pulse_q  <= err_pulse_d;
      at_limit_q   <= at_limit_d;
    end
  end

  assign value      = value_q;
  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign err_pulse  = err_pulse_q;
  assign at_limit   = at_limit_q;

endmodule
